// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall / bubble / flush sequencing for the ID/EX pipeline register and its
// neighbours (PC, IF/ID) in a 5-stage RISC-V pipeline. Three hazard sources
// are resolved with priority mem_busy > taken branch > load-use. A memory
// wait freezes the pipeline and resumes whichever stall/flush sequence was
// in progress, with its remaining count intact.
module pipeline_hazard_ctrl #(
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int LOAD_LATENCY     = 1,
    parameter int BRANCH_PENALTY   = 1,
    parameter int CNT_W            = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [REG_NUM_BITWIDTH-1:0] id_rs1,
    input  logic [REG_NUM_BITWIDTH-1:0] id_rs2,
    input  logic                        id_use_rs1,
    input  logic                        id_use_rs2,
    input  logic                        ex_memRead,
    input  logic [REG_NUM_BITWIDTH-1:0] ex_rd,
    input  logic                        ex_branch_taken,
    input  logic                        mem_busy,
    output logic                        pc_write,
    output logic                        ifid_write,
    output logic                        ifid_flush,
    output logic                        idex_bubble,
    output logic                        pipe_hold,
    output logic [1:0]                  state,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            flush_cnt
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_LSTALL = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [1:0] S_MWAIT  = 2'd3;

    // Remaining-cycle counts loaded on entry to LSTALL / FLUSH; the entry
    // cycle itself is the first stall/flush cycle.
    localparam logic [3:0] LL_INIT  = 4'(LOAD_LATENCY - 32'sd1);
    localparam logic [3:0] BP_INIT  = 4'(BRANCH_PENALTY - 32'sd1);
    localparam bit         LL_MULTI = (LOAD_LATENCY > 32'sd1);
    localparam bit         BP_MULTI = (BRANCH_PENALTY > 32'sd1);

    localparam logic [CNT_W-1:0]            CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]            CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [REG_NUM_BITWIDTH-1:0] REG_X0  = {REG_NUM_BITWIDTH{1'b0}};

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [1:0]       saved_r;
    logic [1:0]       saved_nxt_s;
    logic [3:0]       cnt_r;
    logic [3:0]       cnt_nxt_s;
    logic [1:0]       eff_s;
    logic             lu_s;
    logic             flush_evt_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // x0 is hardwired zero, so a load targeting it never creates a hazard.
    assign lu_s = ex_memRead && (ex_rd != REG_X0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd)));

    // Leaving MWAIT evaluates the saved state in the same cycle.
    assign eff_s = ((state_r == S_MWAIT) && !mem_busy) ? saved_r : state_r;

    assign state     = state_r;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

    // State register: current state, state saved across MWAIT, remaining count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_RUN;
            saved_r <= S_RUN;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            saved_r <= saved_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic with memory wait taking precedence over everything.
    always_comb begin
        state_nxt_s = state_r;
        saved_nxt_s = saved_r;
        cnt_nxt_s   = cnt_r;
        flush_evt_s = 1'b0;
        if (mem_busy) begin
            state_nxt_s = S_MWAIT;
            if (state_r != S_MWAIT) begin
                saved_nxt_s = state_r;
            end else begin
                saved_nxt_s = saved_r;
            end
        end else begin
            case (eff_s)
                S_RUN: begin
                    state_nxt_s = S_RUN;
                    cnt_nxt_s   = 4'd0;
                    if (ex_branch_taken) begin
                        flush_evt_s = 1'b1;
                        if (BP_MULTI) begin
                            state_nxt_s = S_FLUSH;
                            cnt_nxt_s   = BP_INIT;
                        end else begin
                            state_nxt_s = S_RUN;
                        end
                    end else if (lu_s) begin
                        if (LL_MULTI) begin
                            state_nxt_s = S_LSTALL;
                            cnt_nxt_s   = LL_INIT;
                        end else begin
                            state_nxt_s = S_RUN;
                        end
                    end else begin
                        state_nxt_s = S_RUN;
                    end
                end
                S_LSTALL, S_FLUSH: begin
                    if (cnt_r <= 4'd1) begin
                        state_nxt_s = S_RUN;
                        cnt_nxt_s   = 4'd0;
                    end else begin
                        state_nxt_s = eff_s;
                        cnt_nxt_s   = cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_nxt_s = S_RUN;
                    cnt_nxt_s   = 4'd0;
                end
            endcase
        end
    end

    // Output decode: reset forces a bubble, memory wait freezes the pipe.
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        if (rst) begin
            idex_bubble = 1'b1;
        end else if (mem_busy) begin
            pipe_hold = 1'b1;
        end else begin
            case (eff_s)
                S_RUN: begin
                    if (ex_branch_taken) begin
                        pc_write    = 1'b1;
                        ifid_write  = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (lu_s) begin
                        idex_bubble = 1'b1;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                    end
                end
                S_LSTALL: begin
                    idex_bubble = 1'b1;
                end
                S_FLUSH: begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
                default: begin
                    pipe_hold = 1'b1;
                end
            endcase
        end
    end

    // Saturating performance counters: stalled cycles and accepted branches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (!pc_write && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_evt_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl. Two instances share the stimulus:
// dut_a (LOAD_LATENCY=1, BRANCH_PENALTY=2, CNT_W=16) and
// dut_b (LOAD_LATENCY=3, BRANCH_PENALTY=1, CNT_W=4).
// Expected control vectors are queued when a cycle is driven and compared on
// the falling edge; counters are compared directly after the active edge.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_memRead, ex_branch_taken, mem_busy;

    logic        a_pc_write, a_ifid_write, a_ifid_flush, a_idex_bubble, a_pipe_hold;
    logic [1:0]  a_state;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic        b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble, b_pipe_hold;
    logic [1:0]  b_state;
    logic [3:0]  b_stall_cnt, b_flush_cnt;

    pipeline_hazard_ctrl #(.REG_NUM_BITWIDTH(5), .LOAD_LATENCY(1), .BRANCH_PENALTY(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memRead(ex_memRead),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(a_pc_write), .ifid_write(a_ifid_write), .ifid_flush(a_ifid_flush),
        .idex_bubble(a_idex_bubble), .pipe_hold(a_pipe_hold), .state(a_state),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipeline_hazard_ctrl #(.REG_NUM_BITWIDTH(5), .LOAD_LATENCY(3), .BRANCH_PENALTY(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memRead(ex_memRead),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(b_pc_write), .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush),
        .idex_bubble(b_idex_bubble), .pipe_hold(b_pipe_hold), .state(b_state),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    // Control vector layout: {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, state[1:0]}
    localparam logic [6:0] M_ALL = 7'b1111111;
    localparam logic [6:0] M_BR  = 7'b1011111;   // ifid_write not checked on a RUN branch cycle

    typedef struct {
        bit         sel;
        logic [6:0] val;
        logic [6:0] mask;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                         input logic mr, input logic [4:0] rd, input logic br, input logic busy);
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        ex_memRead = mr; ex_rd = rd; ex_branch_taken = br; mem_busy = busy;
    endtask

    // One clock cycle: queue the expectation, compare on the falling edge,
    // return just after the following rising edge.
    task automatic step(input string tag, input bit sel, input logic [6:0] val, input logic [6:0] mask);
        exp_t       e;
        string      t;
        logic [6:0] obs;
        exp_q.push_back('{sel, val, mask});
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        obs = e.sel ? {b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble, b_pipe_hold, b_state}
                    : {a_pc_write, a_ifid_write, a_ifid_flush, a_idex_bubble, a_pipe_hold, a_state};
        checks++;
        assert (((obs ^ e.val) & e.mask) === 7'b0000000) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b mask=%b", t, obs, e.val, e.mask);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        drive(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        // Reset: outputs forced, counters cleared, regardless of a pending hazard
        step("rst_out_a", 1'b0, 7'b0001000, M_ALL);
        step("rst_out_b", 1'b1, 7'b0001000, M_ALL);
        chk("rst_stall_a", a_stall_cnt, 32'd0);
        chk("rst_flush_a", a_flush_cnt, 32'd0);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        rst = 1'b0;

        step("run_idle", 1'b0, 7'b1100000, M_ALL);
        chk("idle_stall_a", a_stall_cnt, 32'd0);

        // Load-use, LOAD_LATENCY=1: one stall cycle then RUN
        drive(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        step("lu_stall", 1'b0, 7'b0001000, M_ALL);
        drive(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        step("lu_done", 1'b0, 7'b1100000, M_ALL);
        chk("lu_stall_cnt", a_stall_cnt, 32'd1);

        // x0 destination and unused rs2 never stall
        drive(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        step("x0_no_stall", 1'b0, 7'b1100000, M_ALL);
        drive(5'd3, 1'b1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
        step("unused_rs2", 1'b0, 7'b1100000, M_ALL);
        chk("x0_stall_cnt", a_stall_cnt, 32'd1);

        // Branch, BRANCH_PENALTY=2: RUN -> FLUSH -> RUN
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        step("br_c0", 1'b0, 7'b1011000, M_BR);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        step("br_c1", 1'b0, 7'b1111010, M_ALL);
        step("br_after", 1'b0, 7'b1100000, M_ALL);
        chk("br_flush_cnt", a_flush_cnt, 32'd1);
        chk("br_stall_cnt", a_stall_cnt, 32'd1);

        // Reset asserted mid-FLUSH clears state and counters without a clock edge
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        step("br2_c0", 1'b0, 7'b1011000, M_BR);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("mid_flush_state", a_state, 32'd2);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_state", a_state, 32'd0);
        chk("async_rst_flush", a_flush_cnt, 32'd0);
        chk("async_rst_stall", a_stall_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_rst_run", 1'b0, 7'b1100000, M_ALL);

        // Priority on dut_b: branch beats load-use, no LSTALL entry
        drive(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
        step("prio_br_lu", 1'b1, 7'b1011000, M_BR);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        step("prio_no_lstall", 1'b1, 7'b1100000, M_ALL);
        chk("prio_flush_cnt", b_flush_cnt, 32'd1);
        chk("prio_stall_cnt", b_stall_cnt, 32'd0);
        // mem_busy beats branch: freeze, branch not counted
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        step("prio_busy_br", 1'b1, 7'b0000100, M_ALL);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        step("mw_exit_run", 1'b1, 7'b1100011, M_ALL);
        chk("busy_br_flush_cnt", b_flush_cnt, 32'd1);
        chk("busy_br_stall_cnt", b_stall_cnt, 32'd1);
        step("mw_back_run", 1'b1, 7'b1100000, M_ALL);

        // Load-use with LOAD_LATENCY=3, memory wait for 4 cycles at the second stall cycle
        do_reset();
        drive(5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
        step("lw_s0", 1'b1, 7'b0001000, M_ALL);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        step("lw_busy0", 1'b1, 7'b0000101, M_ALL);
        for (int i = 0; i < 3; i++) begin
            step("lw_busy_mw", 1'b1, 7'b0000111, M_ALL);
        end
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        step("lw_resume0", 1'b1, 7'b0001011, M_ALL);
        step("lw_resume1", 1'b1, 7'b0001001, M_ALL);
        step("lw_run", 1'b1, 7'b1100000, M_ALL);
        chk("lw_stall_cnt", b_stall_cnt, 32'd7);

        // Saturation of the 4-bit stall counter over 20 frozen cycles
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (i == 0) step("sat_busy_first", 1'b1, 7'b0000100, M_ALL);
            else        step("sat_busy", 1'b1, 7'b0000111, M_ALL);
            if (i == 7 || i == 19) chk("sat_stall_cnt", b_stall_cnt, 32'd15);
        end
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        step("sat_exit", 1'b1, 7'b1100011, M_ALL);
        chk("sat_hold_cnt", b_stall_cnt, 32'd15);
        chk("sat_flush_a_cnt", a_flush_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
